// File: rtl/booth_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM encodings,
// radix-4 recode patterns and the iteration-count helper.
package booth_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Radix-4 recode patterns {Q[1], Q[0], q_m1}
  localparam logic [2:0] R4_P0  = 3'b000;
  localparam logic [2:0] R4_P1A = 3'b001;
  localparam logic [2:0] R4_P1B = 3'b010;
  localparam logic [2:0] R4_P2  = 3'b011;
  localparam logic [2:0] R4_M2  = 3'b100;
  localparam logic [2:0] R4_M1A = 3'b101;
  localparam logic [2:0] R4_M1B = 3'b110;
  localparam logic [2:0] R4_M0  = 3'b111;

  function automatic int unsigned iter_of(input int unsigned width, input int unsigned radix);
    return (radix == 4) ? width / 2 : width;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product selector: maps recode bits to a signed addend
// (0, +-M, +-2M) at the accumulator width WIDTH+2.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADIX = 2
) (
  input  logic [2:0]       recode,
  input  logic [WIDTH+1:0] m_ext,
  output logic [WIDTH+1:0] pp_c
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0] m2;
  assign m2 = {m_ext[AW-2:0], 1'b0};

  always_comb begin
    pp_c = '0;
    if (RADIX == 4) begin
      case (recode)
        R4_P1A, R4_P1B: pp_c = m_ext;
        R4_P2:          pp_c = m2;
        R4_M2:          pp_c = -m2;
        R4_M1A, R4_M1B: pp_c = -m_ext;
        default:        pp_c = '0;
      endcase
    end else begin
      case (recode[1:0])
        2'b01:   pp_c = m_ext;
        2'b10:   pp_c = -m_ext;
        default: pp_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential signed Booth multiplier (radix 2 or 4): control FSM, step
// counter and {A,Q,q_m1} shift datapath.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADIX = 2,
  localparam int unsigned ITER  = iter_of(WIDTH, RADIX),
  localparam int unsigned CNT_W = $clog2(ITER) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     cnt,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned AW = WIDTH + 2;

  if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
    $error("booth_seq_mul: RADIX must be 2 or 4");
  end
  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_seq_mul: WIDTH must be even and >= 4");
  end

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [2:0]         recode;
  logic [AW-1:0]      pp, sum, a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               qm1_sh;

  assign recode = (RADIX == 4) ? {q_q[1:0], qm1_q} : {1'b0, q_q[0], qm1_q};

  booth_pp_sel #(.WIDTH(WIDTH), .RADIX(RADIX)) u_pp_sel (
    .recode (recode),
    .m_ext  (m_q),
    .pp_c   (pp)
  );

  assign sum = a_q + pp;

  // Arithmetic right shift of {A,Q,q_m1} by one Booth step
  always_comb begin
    if (RADIX == 4) begin
      a_sh   = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_sh   = {sum[1:0], q_q[WIDTH-1:2]};
      qm1_sh = q_q[1];
    end else begin
      a_sh   = {sum[AW-1], sum[AW-1:1]};
      q_sh   = {sum[0], q_q[WIDTH-1:1]};
      qm1_sh = q_q[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    m_d      = m_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      a_d      = '0;
      m_d      = '0;
      q_d      = '0;
      qm1_d    = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_start) begin
            m_d     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            q_d     = multiplier;
            a_d     = '0;
            qm1_d   = 1'b0;
            cnt_d   = CNT_W'(ITER);
            state_d = EXEC;
          end
        end
        EXEC: begin
          a_d   = a_sh;
          q_d   = q_sh;
          qm1_d = qm1_sh;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = {a_sh[WIDTH-1:0], q_sh};
            state_d  = DONE;
          end
        end
        DONE: begin
          if (!op_start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == EXEC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      m_q      <= m_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign state   = state_q;
  assign cnt     = cnt_q;
  assign op_busy = busy_q;
  assign op_done = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Scoreboard bench: radix-2 and radix-4 WIDTH=8 instances share stimulus;
// per-instance monitors check product and latency on each op_done rise.
module tb_booth_seq_mul;

  logic       clk;
  logic       reset_n;
  logic       op_start;
  logic       op_clear;
  logic [7:0] multiplicand;
  logic [7:0] multiplier;

  logic [1:0]  state2, state4;
  logic [3:0]  cnt2;
  logic [2:0]  cnt4;
  logic        busy2, busy4, done2, done4;
  logic [15:0] result2, result4;

  booth_seq_mul #(.WIDTH(8), .RADIX(2)) u_r2 (
    .clk (clk), .reset_n (reset_n), .op_start (op_start), .op_clear (op_clear),
    .multiplicand (multiplicand), .multiplier (multiplier),
    .state (state2), .cnt (cnt2), .op_busy (busy2), .op_done (done2), .result (result2)
  );

  booth_seq_mul #(.WIDTH(8), .RADIX(4)) u_r4 (
    .clk (clk), .reset_n (reset_n), .op_start (op_start), .op_clear (op_clear),
    .multiplicand (multiplicand), .multiplier (multiplier),
    .state (state4), .cnt (cnt4), .op_busy (busy4), .op_done (done4), .result (result4)
  );

  typedef struct {
    logic [15:0] prod;
    int          start;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  int   cyc;
  int   n_tests;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expectation whenever op_done rises
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done2 && !prev) begin
        if (q2.size() == 0) chk("r2 unexpected done", 64'(result2), 64'hx);
        else begin
          e = q2.pop_front();
          chk("r2 product", 64'(result2), 64'(e.prod));
          chk("r2 latency", 64'(cyc - e.start), 64'd8);
        end
      end
      prev = done2;
    end
  end

  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done4 && !prev) begin
        if (q4.size() == 0) chk("r4 unexpected done", 64'(result4), 64'hx);
        else begin
          e = q4.pop_front();
          chk("r4 product", 64'(result4), 64'(e.prod));
          chk("r4 latency", 64'(cyc - e.start), 64'd4);
        end
      end
      prev = done4;
    end
  end

  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                        input bit chk_cnt);
    exp_t e;
    bit   stable;
    bit   both;
    @(negedge clk);
    op_start     = 1'b1;
    multiplicand = m;
    multiplier   = q;
    e.prod  = exp;
    e.start = cyc + 1;
    q2.push_back(e);
    q4.push_back(e);
    both = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        multiplicand = ~m;
        multiplier   = q ^ 8'h5A;
      end
      if (chk_cnt && k <= 8) begin
        chk("r2 cnt", 64'(cnt2), 64'(8 - k));
        chk("r4 cnt", 64'(cnt4), (k < 4) ? 64'(4 - k) : 64'd0);
      end
      if (done2 && done4) begin
        both = 1'b1;
        break;
      end
    end
    if (!both) chk("done timeout", 64'(both), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result2 !== exp || result4 !== exp || !done2 || !done4) stable = 1'b0;
    end
    chk("done hold stable", 64'(stable), 64'd1);
    op_start = 1'b0;
    @(negedge clk);
    chk("r2 idle after drop", 64'(state2), 64'd0);
    chk("r4 idle after drop", 64'(state4), 64'd0);
    chk("r2 result held", 64'(result2), 64'(exp));
    chk("r4 done fell", 64'(done4), 64'd0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("reset state", 64'({state2, state4}), 64'd0);
    chk("reset cnt", 64'({cnt2, cnt4}), 64'd0);
    chk("reset flags", 64'({busy2, done2, busy4, done4}), 64'd0);
    chk("reset result", 64'({result2, result4}), 64'd0);
    reset_n = 1'b1;

    // start and clear together in IDLE: clear wins
    @(negedge clk);
    op_start = 1'b1;
    op_clear = 1'b1;
    multiplicand = 8'd7;
    multiplier   = 8'd3;
    @(negedge clk);
    chk("clear beats start state", 64'({state2, state4}), 64'd0);
    chk("clear beats start busy", 64'({busy2, busy4}), 64'd0);
    op_start = 1'b0;
    op_clear = 1'b0;

    run_op(8'sd7,    -8'sd3,   16'hFFEB, 1'b1);
    run_op(8'h80,    8'h80,    16'h4000, 1'b0);
    run_op(8'sd127,  8'h80,    16'hC080, 1'b0);
    run_op(8'h80,    8'sd127,  16'hC080, 1'b0);
    run_op(8'sd127,  8'sd127,  16'h3F01, 1'b0);
    run_op(8'hFF,    8'hFF,    16'h0001, 1'b0);
    run_op(8'd0,     -8'sd77,  16'h0000, 1'b0);
    run_op(-8'sd5,   8'sd3,    16'hFFF1, 1'b0);
    run_op(8'sd100,  -8'sd50,  16'hEC78, 1'b0);
    run_op(8'sd1,    8'h80,    16'hFF80, 1'b0);

    // op_clear at the third EXEC step with op_start held
    @(negedge clk);
    op_start = 1'b1;
    multiplicand = 8'sd7;
    multiplier   = -8'sd3;
    repeat (3) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    chk("clear state", 64'({state2, state4}), 64'd0);
    chk("clear cnt", 64'({cnt2, cnt4}), 64'd0);
    chk("clear result", 64'({result2, result4}), 64'd0);
    chk("clear no done", 64'({done2, done4}), 64'd0);
    op_clear = 1'b0;
    op_start = 1'b0;
    repeat (2) @(negedge clk);
    run_op(8'sd5, 8'sd6, 16'h001E, 1'b0);

    // asynchronous reset mid-EXEC
    @(negedge clk);
    op_start = 1'b1;
    multiplicand = 8'sd100;
    multiplier   = -8'sd50;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst state", 64'({state2, state4}), 64'd0);
    chk("async rst cnt", 64'({cnt2, cnt4}), 64'd0);
    chk("async rst flags", 64'({busy2, done2, busy4, done4}), 64'd0);
    chk("async rst result", 64'({result2, result4}), 64'd0);
    @(negedge clk);
    op_start = 1'b0;
    reset_n  = 1'b1;
    run_op(-8'sd7, 8'sd9, 16'hFFC1, 1'b0);

    repeat (3) @(negedge clk);
    chk("r2 queue drained", 64'(q2.size()), 64'd0);
    chk("r4 queue drained", 64'(q4.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
